// File: rtl/pc_sequencer_pkg.sv
// Shared types and default addresses for the MIPS PC sequencer.
// Optional delay-slot build is selected with PC_DELAY_SLOT_EN.
package mips_pc_pkg;

    typedef enum logic [2:0] {
        RT_BR   = 3'd0,
        RT_J    = 3'd1,
        RT_JR   = 3'd2,
        RT_EXC  = 3'd3,
        RT_ERET = 3'd4
    } redir_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DSLOT = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0040_0004;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-side and fetch-side signals of the PC sequencer.
// master drives control inputs; slave is the sequencer.
interface pc_sequencer_if;
    import mips_pc_pkg::*;

    logic        stall;
    logic        imem_ready;
    logic        redir_valid;
    redir_t      redir_type;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_target;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        redir_taken;
    logic        addr_err;

    modport master (
        output stall, imem_ready, redir_valid, redir_type, br_taken,
        output imm16, imm26, jr_target, epc,
        input  pc, pc_plus4, fetch_valid, redir_taken, addr_err
    );

    modport slave (
        input  stall, imem_ready, redir_valid, redir_type, br_taken,
        input  imm16, imm26, jr_target, epc,
        output pc, pc_plus4, fetch_valid, redir_taken, addr_err
    );

endinterface

// File: rtl/pc_sequencer_target_calc.sv
// Combinational redirect target selection and JR alignment check.
// Same logic in both PC_DELAY_SLOT_EN builds.
module pc_target_calc
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] pc_plus4,
    input  redir_t      redir_type,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    input  logic [31:0] epc,
    output logic [31:0] target,
    output logic        jr_misaligned
);

    logic [31:0] br_off;

    assign br_off        = {{14{imm16[15]}}, imm16, 2'b00};
    assign jr_misaligned = |jr_target[1:0];

    // pick the target address for the redirect kind
    always_comb begin
        target = pc_plus4;
        case (redir_type)
            RT_BR:   target = pc_plus4 + br_off;
            RT_J:    target = {pc_plus4[31:28], imm26, 2'b00};
            RT_JR:   target = {jr_target[31:2], 2'b00};
            RT_EXC:  target = EXC_VECTOR;
            RT_ERET: target = epc;
            default: target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch FSM and redirect pulses for the MIPS core.
// Define PC_DELAY_SLOT_EN for architectural branch delay slots.
module pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    pc_state_t   state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        jr_misaligned;
    logic        fv_q;
    logic        rt_q;
    logic        ae_q;
    logic        adv;
    logic        is_exc;
    logic        is_eret;
    logic        is_flow;
    logic        is_jr;
`ifdef PC_DELAY_SLOT_EN
    logic [31:0] tgt_q;
`endif

    assign pc_plus4 = pc_q + 32'd4;
    assign adv      = fv_q & bus.imem_ready & ~bus.stall;
    assign is_exc   = bus.redir_valid & (bus.redir_type == RT_EXC);
    assign is_eret  = bus.redir_valid & (bus.redir_type == RT_ERET);
    assign is_jr    = bus.redir_valid & (bus.redir_type == RT_JR);
    assign is_flow  = bus.redir_valid &
                      (((bus.redir_type == RT_BR) & bus.br_taken) |
                       (bus.redir_type == RT_J) |
                       (bus.redir_type == RT_JR));

    pc_target_calc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_calc (
        .pc_plus4      (pc_plus4),
        .redir_type    (bus.redir_type),
        .imm16         (bus.imm16),
        .imm26         (bus.imm26),
        .jr_target     (bus.jr_target),
        .epc           (bus.epc),
        .target        (target),
        .jr_misaligned (jr_misaligned)
    );

    // fetch FSM: EXC overrides everything, others act only on adv
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fv_q    <= 1'b0;
            rt_q    <= 1'b0;
            ae_q    <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
            tgt_q   <= '0;
`endif
        end else begin
            rt_q <= 1'b0;
            ae_q <= 1'b0;
            if (is_exc) begin
                pc_q    <= target;
                state_q <= ST_RUN;
                fv_q    <= 1'b1;
                rt_q    <= 1'b1;
`ifdef PC_DELAY_SLOT_EN
                tgt_q   <= '0;
`endif
            end else begin
                unique case (state_q)
                    ST_BOOT: begin
                        state_q <= ST_RUN;
                        fv_q    <= 1'b1;
                    end
                    ST_RUN: begin
                        if (adv) begin
                            if (is_eret) begin
                                pc_q <= target;
                                rt_q <= 1'b1;
                            end else if (is_flow) begin
`ifdef PC_DELAY_SLOT_EN
                                pc_q    <= pc_plus4;
                                tgt_q   <= target;
                                state_q <= ST_DSLOT;
`else
                                pc_q    <= target;
`endif
                                rt_q <= 1'b1;
                                ae_q <= is_jr & jr_misaligned;
                            end else begin
                                pc_q <= pc_plus4;
                            end
                        end
                    end
`ifdef PC_DELAY_SLOT_EN
                    ST_DSLOT: begin
                        if (adv) begin
                            state_q <= ST_RUN;
                            if (is_eret) begin
                                pc_q <= target;
                                rt_q <= 1'b1;
                            end else begin
                                pc_q <= tgt_q;
                            end
                        end
                    end
`endif
                    default: begin
                        state_q <= ST_RUN;
                    end
                endcase
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = fv_q;
    assign bus.redir_taken = rt_q;
    assign bus.addr_err    = ae_q;

endmodule
